// File: rtl/seqchk_pkg.sv
// seqchk shared types and constants.
// State encoding, data width and run-counter width.
package seqchk_pkg;

    localparam int DATA_W = 32;
    localparam int RUN_W  = 4;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/seqchk_satcnt.sv
// seqchk saturating error counter.
// Increments until all-ones, synchronous clear.
module seqchk_satcnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // count up on inc, stick at all-ones, clr wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seqchk.sv
// seqchk: lock checker for an incrementing-word source.
// Optional SEQCHK_STATS_EN adds an accepted-word counter.
module seqchk
    import seqchk_pkg::*;
#(
    parameter int LOCK_RUN = 4,
    parameter int ERR_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_val,
    output logic              in_rdy,
    input  logic [DATA_W-1:0] in_msg,
    input  logic              clear,
    output logic              lock,
    output logic [ERR_W-1:0]  err_count,
`ifdef SEQCHK_STATS_EN
    output logic [DATA_W-1:0] last_bad,
    output logic [31:0]       word_count
`else
    output logic [DATA_W-1:0] last_bad
`endif
);

    localparam logic [RUN_W-1:0] LOCK_TGT = RUN_W'(LOCK_RUN);

    seq_state_t        state;
    logic [DATA_W-1:0] expected;
    logic [RUN_W-1:0]  run;
    logic [RUN_W-1:0]  run_inc;
    logic              rdy_q;
    logic              accept;
    logic              match;
    logic              brk;

    assign in_rdy  = rdy_q & ~clear;
    assign accept  = in_val & in_rdy;
    assign match   = (in_msg == expected);
    assign run_inc = run + 1'b1;
    assign brk     = accept & (state == LOCKED) & ~match;

    seqchk_satcnt #(
        .W (ERR_W)
    ) u_errcnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (brk),
        .count (err_count)
    );

    // tracking FSM with registered lock and last_bad
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= SEARCH;
            expected <= '0;
            run      <= '0;
            lock     <= 1'b0;
            last_bad <= '0;
            rdy_q    <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (clear) begin
                state    <= SEARCH;
                run      <= '0;
                lock     <= 1'b0;
                last_bad <= '0;
            end else if (accept) begin
                unique case (state)
                    SEARCH: begin
                        expected <= in_msg + 1'b1;
                        run      <= RUN_W'(1);
                        if (LOCK_RUN <= 1) begin
                            state <= LOCKED;
                            lock  <= 1'b1;
                        end else begin
                            state <= ACQUIRE;
                            lock  <= 1'b0;
                        end
                    end
                    ACQUIRE: begin
                        if (match) begin
                            expected <= expected + 1'b1;
                            run      <= run_inc;
                            if (run_inc >= LOCK_TGT) begin
                                state <= LOCKED;
                                lock  <= 1'b1;
                            end
                        end else begin
                            expected <= in_msg + 1'b1;
                            run      <= RUN_W'(1);
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            expected <= expected + 1'b1;
                        end else begin
                            last_bad <= in_msg;
                            expected <= in_msg + 1'b1;
                            run      <= RUN_W'(1);
                            state    <= ACQUIRE;
                            lock     <= 1'b0;
                        end
                    end
                    default: begin
                        state <= SEARCH;
                        lock  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef SEQCHK_STATS_EN
    // wrapping count of every accepted word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_count <= '0;
        end else if (clear) begin
            word_count <= '0;
        end else if (accept) begin
            word_count <= word_count + 1'b1;
        end
    end
`endif

endmodule
